// File: rtl/main_control.sv
// Main control decoder: opcode -> registered datapath controls, with stall/flush.
// Optional macro MAIN_CONTROL_RV32I_EXT_EN adds I-type ALU, LUI and JAL decode.
module main_control #(
  parameter bit OPCODE_BIT_REVERSED = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       opcode_valid,
  input  logic       stall,
  input  logic       flush,
  output logic       alu_src,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       branch,
  output logic [1:0] alu_op,
  output logic       illegal
);

  typedef struct packed {
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [1:0] alu_op;
    logic       illegal;
  } ctrl_t;

  localparam logic [6:0] OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
`ifdef MAIN_CONTROL_RV32I_EXT_EN
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
`endif

  logic [6:0] norm_opcode;
  ctrl_t      dec;
  ctrl_t      ctrl_q;

  always_comb begin
    norm_opcode = '0;
    for (int i = 0; i < 7; i++) begin
      norm_opcode[i] = OPCODE_BIT_REVERSED ? opcode[6-i] : opcode[i];
    end
  end

  always_comb begin
    // NOTE: assign a full default before the case so no path leaves dec unassigned (no latch).
    dec = '0;
    if (opcode_valid) begin
      unique case (norm_opcode)
        OP_R_TYPE: begin dec.reg_write = 1'b1; dec.alu_op = 2'b10; end
        OP_LOAD: begin
          dec.alu_src    = 1'b1;
          dec.mem_to_reg = 1'b1;
          dec.reg_write  = 1'b1;
          dec.mem_read   = 1'b1;
        end
        OP_STORE:  begin dec.alu_src = 1'b1; dec.mem_write = 1'b1; end
        OP_BRANCH: begin dec.branch = 1'b1; dec.alu_op = 2'b01; end
`ifdef MAIN_CONTROL_RV32I_EXT_EN
        OP_I_ALU: begin dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_op = 2'b11; end
        OP_LUI:   begin dec.alu_src = 1'b1; dec.reg_write = 1'b1; end
        OP_JAL:   begin dec.reg_write = 1'b1; dec.branch = 1'b1; end
`endif
        default:  dec.illegal = 1'b1;
      endcase
    end
  end

  // Flush outranks stall so a squashed slot never holds a stale instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments to avoid simulation ordering races.
    if (!rst_n)      ctrl_q <= '0;
    else if (flush)  ctrl_q <= '0;
    else if (!stall) ctrl_q <= dec;
  end

  assign alu_src    = ctrl_q.alu_src;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign reg_write  = ctrl_q.reg_write;
  assign mem_read   = ctrl_q.mem_read;
  assign mem_write  = ctrl_q.mem_write;
  assign branch     = ctrl_q.branch;
  assign alu_op     = ctrl_q.alu_op;
  assign illegal    = ctrl_q.illegal;

endmodule

// File: tb/tb_main_control.sv
// Scoreboard bench for main_control: bit-reversed and straight-order instances
// are driven with the same normalised opcode and must produce identical controls.
module tb_main_control;

  // Packed as {alu_src, mem_to_reg, reg_write, mem_read, mem_write, branch, alu_op, illegal}
  localparam logic [8:0] E_ZERO   = 9'b0_0_0_0_0_0_00_0;
  localparam logic [8:0] E_RTYPE  = 9'b0_0_1_0_0_0_10_0;
  localparam logic [8:0] E_LOAD   = 9'b1_1_1_1_0_0_00_0;
  localparam logic [8:0] E_STORE  = 9'b1_0_0_0_1_0_00_0;
  localparam logic [8:0] E_BRANCH = 9'b0_0_0_0_0_1_01_0;
  localparam logic [8:0] E_ILL    = 9'b0_0_0_0_0_0_00_1;
`ifdef MAIN_CONTROL_RV32I_EXT_EN
  localparam logic [8:0] E_IALU   = 9'b1_0_1_0_0_0_11_0;
  localparam logic [8:0] E_LUI    = 9'b1_0_1_0_0_0_00_0;
  localparam logic [8:0] E_JAL    = 9'b0_0_1_0_0_1_00_0;
`else
  localparam logic [8:0] E_IALU   = E_ILL;
  localparam logic [8:0] E_LUI    = E_ILL;
  localparam logic [8:0] E_JAL    = E_ILL;
`endif

  typedef struct {
    string      name;
    logic [8:0] exp;
  } sb_entry_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode_rev, opcode_str;
  logic       opcode_valid, stall, flush;
  logic       a_src0, m2r0, rw0, mr0, mw0, br0, ill0;
  logic       a_src1, m2r1, rw1, mr1, mw1, br1, ill1;
  logic [1:0] aop0, aop1;
  logic [8:0] act0, act1;

  int tests = 0;
  int failures = 0;
  sb_entry_t sb[$];

  always #5 clk = ~clk;

  main_control #(.OPCODE_BIT_REVERSED(1'b1)) dut_rev (
    .clk(clk), .rst_n(rst_n), .opcode(opcode_rev), .opcode_valid(opcode_valid),
    .stall(stall), .flush(flush), .alu_src(a_src0), .mem_to_reg(m2r0),
    .reg_write(rw0), .mem_read(mr0), .mem_write(mw0), .branch(br0),
    .alu_op(aop0), .illegal(ill0)
  );

  main_control #(.OPCODE_BIT_REVERSED(1'b0)) dut_str (
    .clk(clk), .rst_n(rst_n), .opcode(opcode_str), .opcode_valid(opcode_valid),
    .stall(stall), .flush(flush), .alu_src(a_src1), .mem_to_reg(m2r1),
    .reg_write(rw1), .mem_read(mr1), .mem_write(mw1), .branch(br1),
    .alu_op(aop1), .illegal(ill1)
  );

  assign act0 = {a_src0, m2r0, rw0, mr0, mw0, br0, aop0, ill0};
  assign act1 = {a_src1, m2r1, rw1, mr1, mw1, br1, aop1, ill1};

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic set_opcode(input logic [6:0] norm);
    logic [6:0] r;
    r = '0;
    for (int i = 0; i < 7; i++) r[i] = norm[6-i];
    opcode_rev = r;
    opcode_str = norm;
  endtask

  // Called just after a falling edge; the next rising edge captures, the monitor checks.
  task automatic apply(input string name, input logic [6:0] norm, input logic v,
                       input logic st, input logic fl, input logic [8:0] exp);
    sb_entry_t e;
    set_opcode(norm);
    opcode_valid = v;
    stall = st;
    flush = fl;
    e.name = name;
    e.exp = exp;
    sb.push_back(e);
    @(negedge clk);
  endtask

  initial begin
    sb_entry_t e;
    forever begin
      @(posedge clk);
      #2;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({e.name, "/rev"}, act0, e.exp);
        check({e.name, "/str"}, act1, e.exp);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    set_opcode(7'b0110011);
    opcode_valid = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    #3;
    check("reset_imm/rev", act0, E_ZERO);
    check("reset_imm/str", act1, E_ZERO);
    repeat (2) @(posedge clk);
    #1;
    check("reset_hold/rev", act0, E_ZERO);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_release/rev", act0, E_ZERO);
    check("reset_release/str", act1, E_ZERO);

    apply("rtype",  7'b0110011, 1'b1, 1'b0, 1'b0, E_RTYPE);
    apply("load",   7'b0000011, 1'b1, 1'b0, 1'b0, E_LOAD);
    apply("store",  7'b0100011, 1'b1, 1'b0, 1'b0, E_STORE);
    apply("branch", 7'b1100011, 1'b1, 1'b0, 1'b0, E_BRANCH);
    apply("illegal_all1",  7'b1111111, 1'b1, 1'b0, 1'b0, E_ILL);
    apply("invalid_all1",  7'b1111111, 1'b0, 1'b0, 1'b0, E_ZERO);
    apply("illegal_again", 7'b1111111, 1'b1, 1'b0, 1'b0, E_ILL);
    apply("flush_clr_ill", 7'b1111111, 1'b1, 1'b0, 1'b1, E_ZERO);
    apply("rtype_load",    7'b0110011, 1'b1, 1'b0, 1'b0, E_RTYPE);
    apply("stall_hold",    7'b0100011, 1'b1, 1'b1, 1'b0, E_RTYPE);
    apply("stall_hold2",   7'b0000011, 1'b1, 1'b1, 1'b0, E_RTYPE);
    apply("stall_flush",   7'b0100011, 1'b1, 1'b1, 1'b1, E_ZERO);
    apply("after_flush",   7'b0100011, 1'b1, 1'b0, 1'b0, E_STORE);
    apply("ext_ialu",      7'b0010011, 1'b1, 1'b0, 1'b0, E_IALU);
    apply("ext_lui",       7'b0110111, 1'b1, 1'b0, 1'b0, E_LUI);
    apply("ext_jal",       7'b1101111, 1'b1, 1'b0, 1'b0, E_JAL);
    apply("load_pre_rst",  7'b0000011, 1'b1, 1'b0, 1'b0, E_LOAD);

    // Asynchronous reset between edges must clear outputs without a clock.
    #1 rst_n = 1'b0;
    #1;
    check("midrst_imm/rev", act0, E_ZERO);
    check("midrst_imm/str", act1, E_ZERO);
    @(negedge clk);
    check("midrst_hold/rev", act0, E_ZERO);
    rst_n = 1'b1;
    apply("post_rst_branch", 7'b1100011, 1'b1, 1'b0, 1'b0, E_BRANCH);

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
